// File: rtl/sys_types.sv
// Shared types and sizing helpers for the tensor PE array.
package sys_types;

  localparam int DEF_LANES = 4;
  localparam int DEF_IN_W  = 8;
  localparam int DEF_ACC_W = 32;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [31:0] int32_t;

  // Width of a full-precision dot product: product width plus carry growth of the lane sum.
  function automatic int pe_dot_w(input int in_w, input int lanes);
    return 2 * in_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/pe_dot_product.sv
// Combinational signed lane multiply and reduction for one PE.
module pe_dot_product
  import sys_types::*;
#(
  parameter  int LANES = DEF_LANES,
  parameter  int IN_W  = DEF_IN_W,
  localparam int DOT_W = pe_dot_w(IN_W, LANES)
) (
  input  logic [LANES*IN_W-1:0] a_i,
  input  logic [LANES*IN_W-1:0] b_i,
  output logic signed [DOT_W-1:0] dot_o
);

  logic signed [2*IN_W-1:0] prod;
  logic signed [DOT_W-1:0]  acc;

  // Multiply each lane pair and sum the sign-extended products at full precision.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod = $signed(a_i[i*IN_W +: IN_W]) * $signed(b_i[i*IN_W +: IN_W]);
      acc  = acc + DOT_W'(prod);
    end
    dot_o = acc;
  end

endmodule

// File: rtl/tensor_pe_vec.sv
// Systolic tensor PE: registered operand pass-through, optional product
// pipeline stage, and a saturating/wrapping accumulator with column drain.
module tensor_pe_vec
  import sys_types::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int IN_W     = DEF_IN_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int PIPE_MUL = 1,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  acc_clear,
  input  logic                  load_sum,
  input  logic [ACC_W-1:0]      sum_in,
  input  logic [LANES*IN_W-1:0] left_in,
  input  logic [LANES*IN_W-1:0] top_in,
  output logic [LANES*IN_W-1:0] right_out,
  output logic [LANES*IN_W-1:0] bottom_out,
  output logic                  valid_out,
  output logic                  clear_out,
  output logic [ACC_W-1:0]      sum_out,
  output logic                  ovf,
  output logic                  busy
);

  localparam int DOT_W = pe_dot_w(IN_W, LANES);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [LANES*IN_W-1:0]   right_q, bottom_q;
  logic                    valid_q, clear_q;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic signed [DOT_W-1:0] dot;
  logic signed [DOT_W-1:0] mac_dot;
  logic                    mac_valid, mac_clear;
  logic [ACC_W-1:0]        mac_ext;
  logic [ACC_W:0]          sum_wide;
  logic                    wide_ovf;

  pe_dot_product #(
    .LANES (LANES),
    .IN_W  (IN_W)
  ) u_dot (
    .a_i   (left_in),
    .b_i   (top_in),
    .dot_o (dot)
  );

  // Operands, valid and clear move to the neighbours every cycle regardless of drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      right_q  <= '0;
      bottom_q <= '0;
      valid_q  <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      right_q  <= left_in;
      bottom_q <= top_in;
      valid_q  <= valid_in;
      clear_q  <= acc_clear;
    end
  end

  if (PIPE_MUL != 0) begin : g_pipe
    logic                    s1_valid_q, s1_clear_q;
    logic signed [DOT_W-1:0] s1_dot_q;

    // Product stage: reset drops whatever beat is in flight.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid_q <= 1'b0;
        s1_clear_q <= 1'b0;
        s1_dot_q   <= '0;
      end else begin
        s1_valid_q <= valid_in;
        s1_clear_q <= acc_clear;
        s1_dot_q   <= dot;
      end
    end

    assign mac_valid = s1_valid_q;
    assign mac_clear = s1_clear_q;
    assign mac_dot   = s1_dot_q;
    assign busy      = s1_valid_q;
  end else begin : g_comb
    assign mac_valid = valid_in;
    assign mac_clear = acc_clear;
    assign mac_dot   = dot;
    assign busy      = 1'b0;
  end

  // Sign-extend the product and add in one extra bit so overflow is the top-two-bit disagreement.
  assign mac_ext  = ACC_W'(mac_dot);
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {mac_ext[ACC_W-1], mac_ext};
  assign wide_ovf = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  // Accumulator next state: drain beats clear beats beats accumulate; otherwise hold.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (load_sum) begin
      acc_d = sum_in;
      ovf_d = 1'b0;
    end else if (mac_valid && mac_clear) begin
      acc_d = mac_ext;
      ovf_d = 1'b0;
    end else if (mac_valid) begin
      acc_d = sum_wide[ACC_W-1:0];
      if (wide_ovf) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) begin
          acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
      end
    end
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign right_out  = right_q;
  assign bottom_out = bottom_q;
  assign valid_out  = valid_q;
  assign clear_out  = clear_q;
  assign sum_out    = acc_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_tensor_pe_vec.sv
// Bench for tensor_pe_vec: default saturating pipelined PE (a_*), wrapping PE (b_*)
// and an 8-lane 4-bit combinational PE (c_*).
module tb_tensor_pe_vec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: defaults ----------------
  logic        a_valid, a_clear, a_load;
  logic [31:0] a_sum_in, a_left, a_top;
  logic [31:0] a_right, a_bottom, a_sum;
  logic        a_valid_out, a_clear_out, a_ovf, a_busy;

  tensor_pe_vec u_a (
    .clk(clk), .reset(rst), .valid_in(a_valid), .acc_clear(a_clear), .load_sum(a_load),
    .sum_in(a_sum_in), .left_in(a_left), .top_in(a_top), .right_out(a_right),
    .bottom_out(a_bottom), .valid_out(a_valid_out), .clear_out(a_clear_out),
    .sum_out(a_sum), .ovf(a_ovf), .busy(a_busy)
  );

  // ---------------- DUT B: wrapping ----------------
  logic        b_valid, b_clear, b_load;
  logic [31:0] b_sum_in, b_left, b_top;
  logic [31:0] b_right, b_bottom, b_sum;
  logic        b_valid_out, b_clear_out, b_ovf, b_busy;

  tensor_pe_vec #(.SATURATE(0)) u_b (
    .clk(clk), .reset(rst), .valid_in(b_valid), .acc_clear(b_clear), .load_sum(b_load),
    .sum_in(b_sum_in), .left_in(b_left), .top_in(b_top), .right_out(b_right),
    .bottom_out(b_bottom), .valid_out(b_valid_out), .clear_out(b_clear_out),
    .sum_out(b_sum), .ovf(b_ovf), .busy(b_busy)
  );

  // ---------------- DUT C: 8 lanes x 4 bit, no product stage ----------------
  logic        c_valid, c_clear, c_load;
  logic [31:0] c_sum_in, c_left, c_top;
  logic [31:0] c_right, c_bottom, c_sum;
  logic        c_valid_out, c_clear_out, c_ovf, c_busy;

  tensor_pe_vec #(.LANES(8), .IN_W(4), .PIPE_MUL(0)) u_c (
    .clk(clk), .reset(rst), .valid_in(c_valid), .acc_clear(c_clear), .load_sum(c_load),
    .sum_in(c_sum_in), .left_in(c_left), .top_in(c_top), .right_out(c_right),
    .bottom_out(c_bottom), .valid_out(c_valid_out), .clear_out(c_clear_out),
    .sum_out(c_sum), .ovf(c_ovf), .busy(c_busy)
  );

  // ---------------- scoreboard for DUT A: {ovf, sum_out} with due cycle ----------------
  logic [32:0] exp_q[$];
  int          due_q[$];

  task automatic push_a(input logic ovf_e, input logic [31:0] sum_e, input int lat);
    exp_q.push_back({ovf_e, sum_e});
    due_q.push_back(cyc + lat);
  endtask

  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [32:0] e;
      int          d;
      e = exp_q.pop_front();
      d = due_q.pop_front();
      n_vec++;
      assert ({a_ovf, a_sum} === e && d == cyc) else begin
        n_err++;
        $error("FAIL sum_a cyc %0d (due %0d): observed %h expected %h", cyc, d, {a_ovf, a_sum}, e);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_a(input logic v, input logic clr, input logic ld, input logic [31:0] si,
                         input logic [31:0] l, input logic [31:0] t);
    a_valid = v; a_clear = clr; a_load = ld; a_sum_in = si; a_left = l; a_top = t;
  endtask

  task automatic drive_b(input logic v, input logic clr, input logic ld, input logic [31:0] si,
                         input logic [31:0] l, input logic [31:0] t);
    b_valid = v; b_clear = clr; b_load = ld; b_sum_in = si; b_left = l; b_top = t;
  endtask

  task automatic drive_c(input logic v, input logic clr, input logic ld, input logic [31:0] si,
                         input logic [31:0] l, input logic [31:0] t);
    c_valid = v; c_clear = clr; c_load = ld; c_sum_in = si; c_left = l; c_top = t;
  endtask

  // ---------------- golden accumulator for random traffic ----------------
  localparam longint ACC_MAX_L = 64'sd2147483647;
  localparam longint ACC_MIN_L = -64'sd2147483648;
  longint m_acc;
  logic   m_ovf;

  task automatic model_mac(input longint dot, input logic clr);
    longint s;
    if (clr) begin
      m_acc = dot;
      m_ovf = 1'b0;
    end else begin
      s = m_acc + dot;
      if (s > ACC_MAX_L) begin
        m_acc = ACC_MAX_L; m_ovf = 1'b1;
      end else if (s < ACC_MIN_L) begin
        m_acc = ACC_MIN_L; m_ovf = 1'b1;
      end else begin
        m_acc = s;
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] wrap_exp;
    logic [31:0] last_left;
    logic        last_v;
    logic        prev_v;

    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    drive_c(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_sum_a", a_sum, 0);
    check("rst_ovf_a", a_ovf, 0);
    check("rst_busy_a", a_busy, 0);
    check("rst_valid_out_a", a_valid_out, 0);
    check("rst_clear_out_a", a_clear_out, 0);
    check("rst_right_a", a_right, 0);
    check("rst_bottom_a", a_bottom, 0);
    check("rst_sum_b", b_sum, 0);
    check("rst_sum_c", c_sum, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clear + MAC: 1*5+2*6+3*7+4*8 = 70, then 70 + 4*(-1*2) = 62
    drive_a(1, 1, 0, 0, 32'h04030201, 32'h08070605);
    push_a(0, 32'd70, 2);
    @(negedge clk);
    check("mac1_valid_out", a_valid_out, 1);
    check("mac1_clear_out", a_clear_out, 1);
    check("mac1_right", a_right, 32'h04030201);
    check("mac1_bottom", a_bottom, 32'h08070605);
    check("mac1_busy", a_busy, 1);
    drive_a(1, 0, 0, 0, 32'hFFFFFFFF, 32'h02020202);
    push_a(0, 32'd62, 2);
    @(negedge clk);
    check("mac2_valid_out", a_valid_out, 1);
    check("mac2_clear_out", a_clear_out, 0);
    check("mac2_right", a_right, 32'hFFFFFFFF);
    drive_a(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("idle_valid_out", a_valid_out, 0);
    check("idle_busy", a_busy, 0);

    // Drain: accumulate 70, then a beat whose product is in the stage when load_sum hits
    drive_a(1, 1, 0, 0, 32'h04030201, 32'h08070605);
    push_a(0, 32'd70, 2);
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive_a(1, 0, 0, 0, 32'h01010101, 32'h01010101);
    @(negedge clk);
    drive_a(0, 0, 1, 32'd123, 32'h11223344, 32'h55667788);
    push_a(0, 32'd123, 1);
    @(negedge clk);
    check("drain_right", a_right, 32'h11223344);
    check("drain_bottom", a_bottom, 32'h55667788);
    check("drain_valid_out", a_valid_out, 0);
    drive_a(0, 0, 0, 0, 0, 0);
    push_a(0, 32'd123, 1);
    @(negedge clk);

    // Saturation positive: 0x7FFFFFF0 + 4*127*127 clamps to max
    drive_a(0, 0, 1, 32'h7FFFFFF0, 0, 0);
    push_a(0, 32'h7FFFFFF0, 1);
    @(negedge clk);
    drive_a(1, 0, 0, 0, 32'h7F7F7F7F, 32'h7F7F7F7F);
    push_a(1, 32'h7FFFFFFF, 2);
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    // Saturation negative: 0x80000010 + 4*(-128*127) clamps to min
    drive_a(0, 0, 1, 32'h80000010, 0, 0);
    push_a(0, 32'h80000010, 1);
    @(negedge clk);
    drive_a(1, 0, 0, 0, 32'h80808080, 32'h7F7F7F7F);
    push_a(1, 32'h80000000, 2);
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Wrap on the non-saturating instance
    wrap_exp = 32'h7FFFFFF0 + 32'd64516;
    drive_b(0, 0, 1, 32'h7FFFFFF0, 0, 0);
    @(negedge clk);
    drive_b(1, 0, 0, 0, 32'h7F7F7F7F, 32'h7F7F7F7F);
    @(negedge clk);
    drive_b(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wrap_sum_b", b_sum, wrap_exp);
    check("wrap_ovf_b", b_ovf, 1);
    drive_b(1, 1, 0, 0, 32'h04030201, 32'h08070605);
    @(negedge clk);
    drive_b(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wrap_clr_sum_b", b_sum, 70);
    check("wrap_clr_ovf_b", b_ovf, 0);

    // 8-lane 4-bit combinational PE: 8*(-8*-8) = 512, then 512 + 8*(-8*7) = 64
    drive_c(1, 1, 0, 0, 32'h88888888, 32'h88888888);
    @(negedge clk);
    check("c_sum_512", c_sum, 512);
    check("c_ovf", c_ovf, 0);
    check("c_busy", c_busy, 0);
    check("c_valid_out", c_valid_out, 1);
    drive_c(1, 0, 0, 0, 32'h88888888, 32'h77777777);
    @(negedge clk);
    check("c_sum_64", c_sum, 64);
    drive_c(1, 0, 1, 32'd5, 32'h11111111, 32'h11111111);
    @(negedge clk);
    check("c_load_drops_beat", c_sum, 5);
    drive_c(0, 1, 0, 0, 32'h11111111, 32'h11111111);
    @(negedge clk);
    check("c_invalid_ignored", c_sum, 5);
    check("c_clear_out", c_clear_out, 1);
    drive_c(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset mid-tile: second beat arrives with reset; nothing lands afterwards
    drive_a(1, 1, 0, 0, 32'h04030201, 32'h08070605);
    @(negedge clk);
    drive_a(1, 0, 0, 0, 32'hFFFFFFFF, 32'h02020202);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sum", a_sum, 0);
    check("mid_rst_ovf", a_ovf, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_valid_out", a_valid_out, 0);
    check("mid_rst_clear_out", a_clear_out, 0);
    check("mid_rst_right", a_right, 0);
    check("mid_rst_bottom", a_bottom, 0);
    rst = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0);
    push_a(0, 0, 1);
    push_a(0, 0, 2);
    repeat (2) @(negedge clk);

    // Random back-to-back traffic against the golden accumulator
    m_acc = 0;
    m_ovf = 1'b0;
    last_left = '0;
    last_v = 1'b0;
    prev_v = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      logic        v, clr, ld;
      logic [31:0] si, l, t;
      byte         oa, ob;
      longint      dot;
      check("rnd_right", a_right, last_left);
      check("rnd_valid_out", a_valid_out, last_v);
      v   = (k == 0) ? 1'b1 : ($urandom_range(3) != 0);
      clr = (k == 0) ? 1'b1 : ($urandom_range(15) == 0);
      ld  = (k > 0) && !prev_v && ($urandom_range(3) == 0);
      case ($urandom_range(2))
        0:       si = $urandom;
        1:       si = 32'h7FFFF000;
        default: si = 32'h80001000;
      endcase
      dot = 0;
      for (int i = 0; i < 4; i++) begin
        oa = byte'($urandom_range(255));
        ob = byte'($urandom_range(255));
        l[i*8 +: 8] = oa;
        t[i*8 +: 8] = ob;
        dot += longint'(oa) * longint'(ob);
      end
      drive_a(v, clr, ld, si, l, t);
      if (ld) begin
        m_acc = longint'($signed(si));
        m_ovf = 1'b0;
        push_a(m_ovf, m_acc[31:0], 1);
      end
      if (v) begin
        model_mac(dot, clr);
        push_a(m_ovf, m_acc[31:0], 2);
      end
      prev_v = v;
      last_left = l;
      last_v = v;
      @(negedge clk);
    end
    drive_a(0, 0, 0, 0, 0, 0);

    // Bounded drain of outstanding expectations
    repeat (4) @(negedge clk);
    n_vec++;
    assert (due_q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", due_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
